// File: rtl/alu_pkg.sv
// Shared ALU constants: select encoding and the RV32 opcodes the operand
// stage understands. Also imported by the ALU itself.
package alu_pkg;

    // ALU select encoding; bit 2 means subtract.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Major opcodes, instr[6:0].
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values used by the decoder.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Decoder result bundle.
    typedef struct packed {
        logic [3:0] sel;
        logic       use_imm;
        logic       illegal;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: opcode/funct3/funct7_5 to
// {alu select, B-operand source, illegal flag}.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_ctrl_t  o_ctrl
);

    // Decode; anything unrecognised falls back to ADD with B = rs2 and illegal set.
    always_comb begin
        o_ctrl.sel     = ALU_ADD;
        o_ctrl.use_imm = 1'b0;
        o_ctrl.illegal = 1'b0;

        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct3)
                    F3_ADD:  o_ctrl.sel = i_funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_AND:  o_ctrl.sel = ALU_AND;
                    F3_OR:   o_ctrl.sel = ALU_OR;
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                // funct7_5 is deliberately ignored: no SUBI exists.
                case (i_funct3)
                    F3_ADD: begin
                        o_ctrl.sel     = ALU_ADD;
                        o_ctrl.use_imm = 1'b1;
                    end
                    F3_AND: begin
                        o_ctrl.sel     = ALU_AND;
                        o_ctrl.use_imm = 1'b1;
                    end
                    F3_OR: begin
                        o_ctrl.sel     = ALU_OR;
                        o_ctrl.use_imm = 1'b1;
                    end
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                // Address generation: rs1 + imm.
                o_ctrl.sel     = ALU_ADD;
                o_ctrl.use_imm = 1'b1;
            end
            OP_BRANCH: begin
                // Compare via subtract; the ALU zero flag resolves beq/bne.
                o_ctrl.sel = ALU_SUB;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU. Main output register plus
// one skid register so decode can keep streaming across an EX stall.
// in_ready is a flop output (!skid_valid), so it has no combinational path
// from out_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic         flush,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    output logic         illegal
);

    alu_ctrl_t    w_ctrl;
    logic [N-1:0] w_in_b;
    logic         w_in_xfer;
    logic         w_main_free;

    logic [N-1:0] r_main_a;
    logic [N-1:0] r_main_b;
    logic [3:0]   r_main_sel;
    logic         r_main_ill;
    logic         r_main_valid;

    logic [N-1:0] r_skid_a;
    logic [N-1:0] r_skid_b;
    logic [3:0]   r_skid_sel;
    logic         r_skid_ill;
    logic         r_skid_valid;

    alu_ctrl_dec u_dec (
        .i_opcode   (opcode),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_ctrl     (w_ctrl)
    );

    // Input-side operand selection and handshake qualifiers.
    always_comb begin
        w_in_b      = w_ctrl.use_imm ? imm : rs2_data;
        w_in_xfer   = in_valid && !r_skid_valid;
        w_main_free = !r_main_valid || out_ready;
    end

    // Main register: refilled from skid first (older), else from input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_sel   <= ALU_ADD;
            r_main_ill   <= 1'b0;
            r_main_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_a     <= r_skid_a;
                r_main_b     <= r_skid_b;
                r_main_sel   <= r_skid_sel;
                r_main_ill   <= r_skid_ill;
                r_main_valid <= 1'b1;
            end else if (w_in_xfer) begin
                r_main_a     <= rs1_data;
                r_main_b     <= w_in_b;
                r_main_sel   <= w_ctrl.sel;
                r_main_ill   <= w_ctrl.illegal;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end
    end

    // Skid register: absorbs the one transaction accepted while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_sel   <= ALU_ADD;
            r_skid_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // Skid content (if any) moves to main this edge.
            r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_skid_a     <= rs1_data;
            r_skid_b     <= w_in_b;
            r_skid_sel   <= w_ctrl.sel;
            r_skid_ill   <= w_ctrl.illegal;
            r_skid_valid <= 1'b1;
        end
    end

    // Outputs come straight from flops.
    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign alu_a     = r_main_a;
    assign alu_b     = r_main_b;
    assign alu_sel   = r_main_sel;
    assign illegal   = r_main_ill;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register stage directly upstream of the ALU. Takes decoded register operands, immediate and instruction fields from decode, generates the 4-bit ALU select and the A/B operands, and presents them to the ALU through a registered valid/ready interface. A two-entry skid buffer lets decode keep streaming while the ALU side stalls. Flush and illegal-op flagging support branch recovery and trap logic.

## Interface
- N, 32, datapath width; matches the ALU width parameter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents a transaction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- rs1_data  in  N  register operand 1.
- rs2_data  in  N  register operand 2.
- imm  in  N  sign-extended immediate.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- flush  in  1  synchronous kill of all held transactions.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  ALU/EX consumer accepts; transfer when out_valid && out_ready.
- alu_a  out  N  ALU input A.
- alu_b  out  N  ALU input B.
- alu_sel  out  4  ALU select.
- illegal  out  1  transaction carries an unsupported opcode/funct.

## Operation
- Select encoding (fixed, shared with ALU): AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110; sel[2] = subtract.
- Decode, evaluated on the input side:
  - R-type (0110011): funct3 000 -> ADD if funct7_5=0, SUB if 1; 111 -> AND; 110 -> OR; B=rs2_data.
  - I-type ALU (0010011): funct3 000 -> ADD, 111 -> AND, 110 -> OR; B=imm. funct7_5 is ignored.
  - Load (0000011) and store (0100011): ADD, B=imm.
  - Branch (1100011): SUB, B=rs2_data. The ALU zero flag resolves beq/bne.
  - Anything else, including unlisted funct3: illegal=1, sel=ADD, B=rs2_data.
  - A=rs1_data in all cases.
- Storage: output register (main) plus one skid register. Each entry holds {a, b, sel, illegal, valid}.
- in_ready = !skid_valid. It is registered, so it carries no combinational path from out_ready.
- Per cycle, main_valid=0 or out_ready=1 (main free or draining):
  - If skid holds data: skid -> main, and skid is cleared.
  - Else, on an input transfer: input -> main.
  - Else: main_valid is cleared.
  - An input transfer while skid is moving to main cannot occur, because in_ready=0 then.
- Per cycle, main_valid=1 and out_ready=0 (stalled): an input transfer is written into skid.
- out_valid=main_valid. alu_a, alu_b, alu_sel and illegal come straight from the main register.
- Outputs stay stable while out_valid=1 and out_ready=0.
- flush: on the next edge, main_valid=0 and skid_valid=0. Any input offered in the flush cycle is dropped. Flush has priority over every capture.

## Timing
- Latency is 1 cycle: input accepted at edge k appears on out_valid after edge k.
- Throughput is 1 transaction/cycle with out_ready held at 1.
- Reset (async assert, sync release by top level): main_valid=0, skid_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_sel=4'b0010, illegal=0.
- Reset mid-stall discards both entries.
- in_ready falls in the cycle after a stalled capture. At most one extra transaction is absorbed after out_ready drops.
- Data is never duplicated or reordered. Ordering is main before skid.

## Structure
- Shared package alu_pkg holds:
  - ALU_AND, ALU_OR, ALU_ADD, ALU_SUB localparams (4-bit).
  - OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH opcode constants.
- alu_pkg is also imported by the ALU.
- One sub-module: alu_ctrl_dec, purely combinational. Maps opcode/funct3/funct7_5 to {alu_sel, use_imm, illegal}.
- The top holds the skid/main registers and the handshake logic.

## Test plan
- R-type ADD then SUB, rs1=7, rs2=5, out_ready=1 -> after 1 cycle: sel=0010, a=7, b=5; next cycle: sel=0110, a=7, b=5.
- ANDI funct3=111, rs1=0xF0F0, imm=0x00FF -> sel=0000, b=0x00FF, illegal=0. Load with imm=-4 -> sel=0010, b=0xFFFFFFFC.
- Opcode 0110111 (LUI) -> illegal=1, sel=0010, out_valid=1.
- Stream 3 transactions with out_ready=0 from the second cycle -> in_ready drops after 2 captures. Raise out_ready -> all 3 emerge in order with no gaps or duplicates.
- Main and skid both full, flush=1 for one cycle -> out_valid=0 and in_ready=1 next cycle. The input offered during flush never appears at the output.
- Assert rst_n=0 asynchronously mid-stall -> outputs go to their reset values immediately, without waiting for clk.
